// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared types and constants for the TDM demux scanner.
// Revision    : 1.0  initial release
// ============================================================================
package tdm_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef logic [NCH-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : tdm_tick_div
// Description : Channel dwell counter; adv pulses on the last cycle of a dwell.
// Revision    : 1.0  initial release
// ============================================================================
module tdm_tick_div #(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic N_RESET,
  input  logic clr,
  input  logic en,
  output logic adv
);

  // Width never drops below one bit so DIV=1 still has a legal counter.
  localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] divcnt;

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      divcnt <= '0;
    end else if (clr) begin
      divcnt <= '0;
    end else if (en) begin
      divcnt <= (divcnt == LAST) ? '0 : divcnt + CNT_W'(1);
    end
  end

  assign adv = en && (divcnt == LAST);

endmodule
`default_nettype wire

// File: rtl/tdm_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tdm_scanner
// Description : Serialises 8-bit words LSB first onto 1-to-8 demux D/SEL lines,
//               holding each channel DIV cycles, with a one-word holding register.
// Revision    : 1.0  initial release
// ============================================================================
module tdm_scanner #(
  parameter int DIV = 1,   // legal range 1..256
  parameter int NCH = 8    // must equal the 3-bit SEL span
) (
  input  logic       CLK,
  input  logic       N_RESET,
  input  logic [7:0] DIN,
  input  logic       LOAD,
  output logic       READY,
  output logic       D,
  output logic [2:0] SEL,
  output logic       BUSY,
  output logic       DONE
);

  import tdm_pkg::*;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

  state_t state;
  word_t  hold;
  word_t  shreg;
  logic   hold_full;
  logic   adv;
  logic   div_clr;
  logic   div_en;
  logic   accept;
  logic   frame_end;
  logic   take;

  assign div_clr   = (state == IDLE);
  assign div_en    = (state == SCAN);
  assign accept    = LOAD && READY;
  assign frame_end = (state == SCAN) && adv && (SEL == LAST_SEL);
  // Hold is consumed when a frame starts from IDLE or chains off a frame end.
  assign take      = hold_full && ((state == IDLE) || frame_end);

  tdm_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .clr     (div_clr),
    .en      (div_en),
    .adv     (adv)
  );

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      hold      <= '0;
      hold_full <= 1'b0;
      READY     <= 1'b1;
    end else if (accept) begin
      hold      <= DIN;
      hold_full <= 1'b1;
      READY     <= 1'b0;
    end else if (take) begin
      hold_full <= 1'b0;
      READY     <= 1'b1;
    end
  end

  // shreg keeps the not-yet-driven bits, so D always comes from bit 0.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state <= IDLE;
      shreg <= '0;
      D     <= 1'b0;
      SEL   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          SEL <= '0;
          if (hold_full) begin
            state <= SCAN;
            shreg <= hold >> 1;
            D     <= hold[0];
            BUSY  <= 1'b1;
          end else begin
            D    <= 1'b0;
            BUSY <= 1'b0;
          end
        end
        SCAN: begin
          if (frame_end) begin
            DONE <= 1'b1;
            SEL  <= '0;
            if (hold_full) begin
              shreg <= hold >> 1;
              D     <= hold[0];
            end else begin
              state <= IDLE;
              D     <= 1'b0;
              BUSY  <= 1'b0;
            end
          end else if (adv) begin
            shreg <= shreg >> 1;
            D     <= shreg[0];
            SEL   <= SEL + SEL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_scanner
// Description : Bench for tdm_scanner; four instances at DIV 1, 2, 3 and 5.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_scanner;

  localparam int NI = 4;

  function automatic int div_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  logic            CLK     = 1'b0;
  logic            N_RESET = 1'b1;
  logic [NI-1:0]   load;
  logic [7:0]      din [NI];
  wire  [NI-1:0]   ready;
  wire  [NI-1:0]   d;
  wire  [NI-1:0]   busy;
  wire  [NI-1:0]   done;
  wire  [3*NI-1:0] sel;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tdm_scanner #(
      .DIV (div_of(g)),
      .NCH (8)
    ) u_dut (
      .CLK     (CLK),
      .N_RESET (N_RESET),
      .DIN     (din[g]),
      .LOAD    (load[g]),
      .READY   (ready[g]),
      .D       (d[g]),
      .SEL     (sel[3*g +: 3]),
      .BUSY    (busy[g]),
      .DONE    (done[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / frame reconstruction ----------------
  typedef struct {
    int         inst;
    logic [7:0] w;
  } sb_t;

  sb_t        sbq[$];
  int         pos    [NI];
  logic [7:0] accw   [NI];
  logic       pend   [NI];
  int         acc_n  [NI];
  int         done_n [NI];

  task automatic pop_compare(input int i, input logic [7:0] got);
    int found;
    found = -1;
    for (int j = 0; j < sbq.size(); j++)
      if (found < 0 && sbq[j].inst == i) found = j;
    if (found < 0) begin
      check($sformatf("frame%0d_unexpected", i), 32'(got), 32'hFFFF_FFFF);
    end else begin
      check($sformatf("frame%0d_word", i), 32'(got), 32'(sbq[found].w));
      sbq.delete(found);
    end
  endtask

  task automatic check_inst(input int i);
    int         dv;
    int         ch;
    logic [2:0] s;
    logic       newpend;
    dv      = div_of(i);
    s       = sel[3*i +: 3];
    newpend = 1'b0;
    if (busy[i]) begin
      ch = pos[i] / dv;
      if (pos[i] % dv == 0) accw[i][ch] = d[i];
      check($sformatf("scan%0d_sel_d", i), 32'({s, d[i]}), 32'({3'(ch), accw[i][ch]}));
      pos[i]++;
      if (pos[i] == 8 * dv) begin
        pop_compare(i, accw[i]);
        pos[i]  = 0;
        newpend = 1'b1;
      end
    end else begin
      check($sformatf("idle%0d_lines", i), 32'({pos[i] != 0, s, d[i]}), 32'd0);
      pos[i] = 0;
    end
    if (done[i] || pend[i])
      check($sformatf("done%0d_pulse", i), 32'(done[i]), 32'(pend[i]));
    if (done[i]) done_n[i]++;
    pend[i] = newpend;
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (!N_RESET) begin
        sbq.delete();
        for (int i = 0; i < NI; i++) begin
          pos[i] = 0; pend[i] = 1'b0; acc_n[i] = 0; done_n[i] = 0;
        end
      end else begin
        for (int i = 0; i < NI; i++) check_inst(i);
      end
      #2;
      if (N_RESET)
        for (int i = 0; i < NI; i++)
          if (load[i] && ready[i]) begin
            sbq.push_back('{inst: i, w: din[i]});
            acc_n[i]++;
          end
    end
  endtask

  // ---------------- directed vector table (instance 0, DIV=1) ----------------
  typedef struct {
    logic       ld;
    logic [7:0] di;
    logic       rdy;
    logic       bsy;
    logic [2:0] sl;
    logic       dd;
    logic       dn;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic ld, input logic [7:0] di, input logic rdy, input logic bsy,
                     input logic [2:0] sl, input logic dd, input logic dn);
    tbl.push_back('{ld: ld, di: di, rdy: rdy, bsy: bsy, sl: sl, dd: dd, dn: dn});
  endtask

  task automatic add_scan(input logic [7:0] w, input int from, input int to, input logic rdy);
    for (int s = from; s <= to; s++) row(1'b0, 8'h00, rdy, 1'b1, 3'(s), w[s], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] wa, wb, wx, wy;
    logic [7:0] y_act, y_exp;
    int         bcnt, dcnt, t;
    int         seln [8];

    load = '0;
    for (int i = 0; i < NI; i++) begin
      din[i] = 8'h00; pos[i] = 0; pend[i] = 1'b0; acc_n[i] = 0; done_n[i] = 0; accw[i] = 8'h00;
    end

    // Reset values, before any clock edge
    #1 N_RESET = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("reset%0d_outputs", i),
            32'({ready[i], busy[i], sel[3*i +: 3], d[i], done[i]}), 32'b1000000);
    repeat (2) @(negedge CLK);
    N_RESET = 1'b1;
    fork
      monitor();
    join_none

    // Single word, frame end; back-to-back with ignored LOAD; frame-end LOAD
    wa = 8'hA5;
    row(1'b1, wa, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add_scan(wa, 0, 7, 1'b1);
    row(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    wa = 8'h3C; wb = 8'hC3;
    row(1'b1, wa,    1'b0, 1'b0, 3'd0, 1'b0,  1'b0);
    row(1'b0, 8'h00, 1'b1, 1'b1, 3'd0, wa[0], 1'b0);
    row(1'b1, wb,    1'b0, 1'b1, 3'd1, wa[1], 1'b0);
    row(1'b1, 8'hFF, 1'b0, 1'b1, 3'd2, wa[2], 1'b0);
    add_scan(wa, 3, 7, 1'b0);
    row(1'b0, 8'h00, 1'b1, 1'b1, 3'd0, wb[0], 1'b1);
    add_scan(wb, 1, 7, 1'b1);
    row(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    wx = 8'h81; wy = 8'h5A;
    row(1'b1, wx, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add_scan(wx, 0, 7, 1'b1);
    row(1'b1, wy,    1'b0, 1'b0, 3'd0, 1'b0,  1'b1);
    row(1'b0, 8'h00, 1'b1, 1'b1, 3'd0, wy[0], 1'b0);
    add_scan(wy, 1, 7, 1'b1);
    row(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    row(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge CLK); #1;
      load[0] = tbl[k].ld;
      din[0]  = tbl[k].di;
      @(posedge CLK); #1;
      check($sformatf("vec%0d_outputs", k),
            32'({ready[0], busy[0], sel[2:0], d[0], done[0]}),
            32'({tbl[k].rdy, tbl[k].bsy, tbl[k].sl, tbl[k].dd, tbl[k].dn}));
      y_act = d[0] ? (8'd1 << sel[2:0]) : 8'd0;
      y_exp = tbl[k].dd ? (8'd1 << tbl[k].sl) : 8'd0;
      check($sformatf("vec%0d_demux_y", k), 32'(y_act), 32'(y_exp));
    end
    @(negedge CLK); #1;
    load[0] = 1'b0;

    // DIV=3, all-ones word: 24 BUSY cycles, each channel held 3 cycles, one DONE
    for (int s = 0; s < 8; s++) seln[s] = 0;
    bcnt = 0; dcnt = 0;
    load[2] = 1'b1; din[2] = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      if (c == 0) load[2] = 1'b0;
      if (busy[2]) begin
        bcnt++;
        seln[sel[8:6]]++;
      end
      if (done[2]) dcnt++;
    end
    check("div3_busy_cycles", 32'(bcnt), 32'd24);
    check("div3_done_count", 32'(dcnt), 32'd1);
    for (int s = 0; s < 8; s++) check($sformatf("div3_dwell_sel%0d", s), 32'(seln[s]), 32'd3);

    // Async reset during SCAN with the holding register full
    @(negedge CLK); #1;
    load[2] = 1'b1; din[2] = 8'h96;
    @(negedge CLK); #1;
    din[2] = 8'h69;
    repeat (2) @(negedge CLK);
    #1 load[2] = 1'b0;
    repeat (4) @(negedge CLK);
    #1 check("pre_reset_busy_full", 32'({busy[2], ready[2]}), 32'b10);
    @(posedge CLK); #2;
    N_RESET = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({ready[2], busy[2], sel[8:6], d[2], done[2]}), 32'b1000000);
    repeat (2) @(negedge CLK);
    #3 N_RESET = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK); #1;
      if (done[2]) dcnt++;
      if (busy[2]) bcnt++;
    end
    check("post_reset_done", 32'(dcnt), 32'd0);
    check("post_reset_busy", 32'(bcnt), 32'd0);

    // Randomised LOAD traffic on every instance
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK); #1;
      for (int i = 0; i < NI; i++) begin
        load[i] = ($urandom_range(0, 2) == 0);
        din[i]  = 8'($urandom);
      end
    end
    @(negedge CLK); #1;
    load = '0;
    t = 0;
    while (t < 400 && !(busy == '0 && ready == '1)) begin
      @(negedge CLK); #1;
      t++;
    end
    check("drain_in_time", 32'(t < 400), 32'd1);
    repeat (3) @(negedge CLK);
    #3;
    for (int i = 0; i < NI; i++)
      check($sformatf("rand%0d_done_vs_accepted", i), 32'(done_n[i]), 32'(acc_n[i]));
    check("scoreboard_leftover", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_scanner.md
Name: tdm_scanner

Overview:
- Upstream stage for the 1-to-8 demultiplexer (inputs D, SEL[2:0]; output Y[7:0]).
- Accepts an 8-bit word over a LOAD/READY handshake and serialises it onto the demux drive lines, one channel at a time, LSB first.
- Each channel is held for DIV clock cycles.
- Outside a frame it drives D=0, so all demux outputs read zero.
- A one-word holding register allows back-to-back frames.

Parameters:
- DIV, 1, clock cycles each channel is held (legal range 1..256).
- NCH, 8, number of channels. Fixed to match the 3-bit SEL; any other value is illegal.

Ports:
- CLK  input  1  system clock, rising-edge active
- N_RESET  input  1  reset, asynchronous, active-low
- DIN  input  8  word to distribute; DIN[i] goes to channel i
- LOAD  input  1  producer offers DIN; transfer occurs on the rising edge where LOAD && READY
- READY  output  1  holding register empty; can accept a word
- D  output  1  data bit to the demux
- SEL  output  3  channel select to the demux
- BUSY  output  1  frame in progress (state SCAN)
- DONE  output  1  one-cycle pulse at end of each frame

Behaviour:
- Clock and reset: one clock (CLK); reset N_RESET is asynchronous, active-low.
- Reset values (all outputs registered): D=0, SEL=0, BUSY=0, DONE=0, READY=1. Internally: holding register empty, state IDLE, both counters 0.
- Reset asserted mid-frame: applies immediately; the frame and any held word are discarded, with no DONE.
- Handshake:
  - A word is captured into the holding register on an edge where LOAD=1 and READY=1.
  - READY = !hold_full.
  - LOAD while READY=0 is ignored; DIN is not sampled.
  - DIN only needs to be stable at the accepting edge.
- States (shared enum): IDLE, SCAN.
- IDLE:
  - D=0, SEL=0, BUSY=0.
  - If hold_full, on the next edge: shift register <= hold, hold emptied, state SCAN, SEL=0, D=hold[0], divcnt=0.
  - Latency: word accepted at edge k -> D/SEL show channel 0 after edge k+1. READY returns high after edge k+1.
- SCAN:
  - BUSY=1. divcnt counts 0..DIV-1; the channel advances when divcnt==DIV-1.
  - If DIV=1, the channel advances every cycle; the counter logic must still be valid (counter width at least 1).
  - Channel advance for SEL<7: SEL+1, D=bit[SEL+1], divcnt=0.
  - Frame end (SEL==7 and divcnt==DIV-1), next edge: DONE=1 for exactly one cycle.
    - If hold_full: the next frame starts seamlessly (SEL=0, D=hold[0], hold emptied, BUSY stays 1, no gap).
    - Else: IDLE, D=0, SEL=0, BUSY=0.
- Frame length: exactly 8*DIV cycles of BUSY per word. D/SEL change only on channel boundaries, so the demux output is glitch-free at cycle level.
- Simultaneous events:
  - A word accepted on the same edge as frame end (hold was empty) does not start seamlessly. It causes one IDLE cycle (D=0), then a new frame.
  - A LOAD during SCAN with hold empty is accepted. READY then drops until that word is transferred into the shift register.
- No word is ever dropped or duplicated. The sequence of frames exactly matches the sequence of accepted words.

Decomposition:
- Package tdm_pkg:
  - typedef enum state_t {IDLE, SCAN}
  - localparam NCH=8, SEL_W=3
  - typedef logic [NCH-1:0] word_t
- One sub-module, tdm_tick_div #(DIV):
  - Ports CLK, N_RESET, clr, en; output adv (high when count==DIV-1 && en).
  - Owns divcnt. The scanner owns the FSM, SEL counter, shift and holding registers.

Test Plan:
1. Reset: N_RESET low asynchronously mid-cycle during SCAN -> immediately D=0, SEL=0, BUSY=0, DONE=0, READY=1; no DONE after release.
2. DIV=1, single word DIN=8'b1010_0101 accepted at edge k -> SEL 0..7 over edges k+1..k+8 with D=1,0,1,0,0,1,0,1; demux Y one-hot matches set bits; DONE high 1 cycle after edge k+9; BUSY low after.
3. DIV=3, DIN=8'hFF -> each SEL value held exactly 3 cycles; BUSY high for 24 cycles; DONE once.
4. Back-to-back, DIV=1: word A accepted, word B loaded during A's frame (READY drops to 0). A third LOAD while full -> ignored, DIN not sampled. At A's end, B's SEL=0 follows SEL=7 with no gap; DONE pulses at each frame end.
5. Word offered on the exact frame-end edge with hold empty -> accepted; one IDLE cycle with D=0; then a full frame.
6. Randomised LOAD with a scoreboard, DIV in {1,2,5} -> reconstructed words equal accepted words in order; count of DONE pulses equals accepted count.
